// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch unit.
//   - WORD / INSTR_LEN        : byte-address and instruction widths
//   - FETCH_FIFO_DEPTH        : default prefetch depth
//   - RESET_PC_DEFAULT        : default fetch address after reset
//   - fetch_entry_t           : one prefetch slot {fault, pc, instruction}
//   - rom_image()             : ROM contents, word i holds value i
//   - addr_faults()           : misaligned / out-of-range test for an issue address
package instr_fetch_unit_pkg;

    localparam int WORD             = 32;
    localparam int INSTR_LEN        = 32;
    localparam int FETCH_FIFO_DEPTH = 4;
    localparam logic [WORD-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic                 fault;
        logic [WORD-1:0]      pc;
        logic [INSTR_LEN-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Program image held in the ROM. The ROM contents come from this
    // function so the array is a pure constant; replace the body to load
    // a different program.
    function automatic logic [INSTR_LEN-1:0] rom_image(input int unsigned idx);
        return INSTR_LEN'(idx);
    endfunction

    // An issue address faults when it is not word aligned or lies at or
    // beyond the last ROM byte. The compare is done in 64 bits so a ROM
    // spanning the whole address space cannot overflow the limit.
    function automatic logic addr_faults(input logic [WORD-1:0] addr,
                                         input longint unsigned limit);
        return (addr[1:0] != 2'b00) || (64'(addr) >= limit);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding prefetched instruction entries.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   flush       - empties the FIFO this edge (wins over push/pop)
//   push, din   - write din when push and a slot is free (or freed by pop)
//   pop, dout   - dout is the head entry; pop removes it when not empty
//   count       - entries held; full / empty status flags
// Handshake: push and pop on the same edge are legal at any occupancy,
// including full, because the popped slot is the one written.
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: word-addressed instruction ROM with registered read,
// sequential fetch-PC generator and a prefetch FIFO presented to decode.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   redirect_valid  - load redirect_pc as the new fetch PC, flush in-flight work
//   redirect_pc     - byte address of the new fetch stream
//   instr_ready     - consumer accepts the head entry this cycle
//   instr_valid     - head entry valid
//   instruction     - head instruction (0 for fault entries and when empty)
//   instr_pc        - byte address of the head instruction (0 when empty)
//   instr_fault     - head entry marks a misaligned / out-of-range fetch
//   fifo_count      - entries currently held in the prefetch FIFO
// Handshake: the head entry transfers on a rising edge where
// instr_valid && instr_ready; while instr_valid && !instr_ready the head
// outputs hold stable. redirect and reset override a same-cycle transfer.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              MEM_WORDS  = 1024,
    parameter int              FIFO_DEPTH = FETCH_FIFO_DEPTH,
    parameter logic [WORD-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [WORD-1:0]               redirect_pc,
    input  logic                          instr_ready,
    output logic                          instr_valid,
    output logic [INSTR_LEN-1:0]          instruction,
    output logic [WORD-1:0]               instr_pc,
    output logic                          instr_fault,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam longint unsigned ROM_BYTES = 64'(MEM_WORDS) * 64'd4;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    // ROM contents are constant; generated from the package image.
    logic [INSTR_LEN-1:0] rom [MEM_WORDS];
    for (genvar i = 0; i < MEM_WORDS; i++) begin : g_rom
        assign rom[i] = rom_image(i);
    end

    logic [WORD-1:0]      fetch_pc;
    logic                 inflight;
    logic [WORD-1:0]      inflight_pc;
    logic                 inflight_fault;
    logic                 halted;
    logic [INSTR_LEN-1:0] rom_data;

    logic [ENTRY_W-1:0]   fifo_din;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    fetch_entry_t         push_entry;
    fetch_entry_t         head;

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 issue_fault;
    logic [CW:0]          occupancy;

    assign pop = !fifo_empty && instr_ready;

    // Credit: entries held plus the read in flight, less the one leaving
    // this edge, must leave room for the read issued now. This keeps every
    // in-flight read backed by a free FIFO slot.
    assign occupancy   = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue       = !reset && !redirect_valid && !halted && (occupancy < DEPTH_C);
    assign issue_fault = addr_faults(fetch_pc, ROM_BYTES);

    // A redirect kills the read completing this cycle.
    assign push = inflight && !redirect_valid;

    always_comb begin
        push_entry       = '0;
        push_entry.fault = inflight_fault;
        push_entry.pc    = inflight_pc;
        push_entry.instr = inflight_fault ? '0 : rom_data;
    end

    assign fifo_din = push_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_fault <= 1'b0;
            halted         <= 1'b0;
            rom_data       <= '0;
        end else if (redirect_valid) begin
            fetch_pc       <= redirect_pc;
            inflight       <= 1'b0;
            inflight_fault <= 1'b0;
            halted         <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= fetch_pc;
                inflight_fault <= issue_fault;
                fetch_pc       <= fetch_pc + WORD'(4);
                if (issue_fault) begin
                    // Fault entry still flows through the in-flight slot so
                    // it lands in order; nothing is fetched after it.
                    halted <= 1'b1;
                end else begin
                    rom_data <= rom[fetch_pc[AW+1:2]];
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = fetch_entry_t'(fifo_dout);

    // Head fields read as zero whenever nothing is valid, which also
    // covers the cycles during and right after reset.
    assign instr_valid = !fifo_empty;
    assign instruction = fifo_empty ? '0 : head.instr;
    assign instr_pc    = fifo_empty ? '0 : head.pc;
    assign instr_fault = fifo_empty ? 1'b0 : head.fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a short randomised scoreboard run.
// ROM image: word i holds i, so a good instruction always equals pc/4.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];

    instr_fetch_unit #(
        .MEM_WORDS  (1024),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault),
        .fifo_count     (fifo_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc,
                              input logic [31:0] ins, input logic flt);
        check({tag, "_valid"}, instr_valid, 1'b1);
        check({tag, "_pc"},    instr_pc,    pc);
        check({tag, "_instr"}, instruction, ins);
        check({tag, "_fault"}, instr_fault, flt);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_count"}, fifo_count,  3'd0);
    endtask

    // drivers: inputs change on the falling edge, outputs sampled there too
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic        model_halted;
    logic [31:0] pc_tmp;
    logic [31:0] tgt;
    logic        redir;

    initial begin
        @(negedge clk);

        // 1: reset for 3 cycles, then free-running stream
        reset       = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_rst_valid", instr_valid, 1'b0);
            check("t1_rst_instr", instruction, 32'h0);
            check("t1_rst_pc",    instr_pc,    32'h0);
            check("t1_rst_fault", instr_fault, 1'b0);
            check("t1_rst_count", fifo_count,  3'd0);
        end
        reset = 1'b0;
        step();
        check("t1_lat1_valid", instr_valid, 1'b0);
        step();
        for (int k = 0; k < 64; k++) begin
            check_head("t1_stream", 32'(k * 4), 32'(k), 1'b0);
            step();
        end

        // 2: backpressure fills the FIFO, head held, then drains in order
        reset       = 1'b1;
        instr_ready = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 1) check_head("t2_hold", 32'h0, 32'h0, 1'b0);
        end
        check("t2_count_full", fifo_count, 3'd4);
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(k * 4));
        instr_ready = 1'b1;
        while (exp_q.size() > 0) begin
            pc_tmp = exp_q.pop_front();
            check_head("t2_drain", pc_tmp, pc_tmp >> 2, 1'b0);
            step();
        end

        // 3: redirect while full
        instr_ready = 1'b0;
        repeat (8) step();
        check("t3_count_full", fifo_count, 3'd4);
        check_head("t3_head", 32'h14, 32'h5, 1'b0);
        do_redirect(32'h100);
        instr_ready = 1'b1;
        check_empty("t3_after_redir");
        step();
        check("t3_gap_valid", instr_valid, 1'b0);
        step();
        check_head("t3_first", 32'h100, 32'h40, 1'b0);
        step();
        check_head("t3_second", 32'h104, 32'h41, 1'b0);

        // 4: run off the end of the ROM, then misaligned target
        do_redirect(32'hFFC);
        check_empty("t4_after_redir");
        step();
        check("t4_gap_valid", instr_valid, 1'b0);
        step();
        check_head("t4_last_word", 32'hFFC, 32'h3FF, 1'b0);
        step();
        check_head("t4_range_fault", 32'h1000, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_halted_valid", instr_valid, 1'b0);
        end
        do_redirect(32'h6);
        step();
        step();
        check_head("t4_misalign_fault", 32'h6, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_halted2_valid", instr_valid, 1'b0);
        end

        // 5a: redirect beats a same-cycle pop; back-to-back redirects
        do_redirect(32'h40);
        step();
        step();
        check_head("t5_pre", 32'h40, 32'h10, 1'b0);
        do_redirect(32'h200);
        check_empty("t5_redir_pop");
        step();
        step();
        check_head("t5_new0", 32'h200, 32'h80, 1'b0);
        step();
        check_head("t5_new1", 32'h204, 32'h81, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 1'b0;
        check_empty("t5_double");
        step();
        step();
        check_head("t5_last_wins", 32'h400, 32'h100, 1'b0);

        // 5b: reset beats a same-cycle redirect
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        check_empty("t5_rst_redir");
        step();
        check("t5_rst_gap", instr_valid, 1'b0);
        step();
        check_head("t5_restart0", 32'h0, 32'h0, 1'b0);
        step();
        check_head("t5_restart1", 32'h4, 32'h1, 1'b0);

        // 6: random ready and redirects against a stream model
        exp_pc       = 32'h80;
        model_halted = 1'b0;
        do_redirect(32'h80);
        for (int c = 0; c < 2000; c++) begin
            instr_ready = 1'($urandom_range(0, 1));
            redir       = ($urandom_range(0, 99) < 3);
            tgt         = 32'($urandom_range(0, 1023)) << 2;
            redirect_valid = redir;
            redirect_pc    = tgt;
            check("t6_count_le4", fifo_count <= 3'd4, 1'b1);
            if (model_halted) check("t6_halted_valid", instr_valid, 1'b0);
            if (redir) begin
                exp_pc       = tgt;
                model_halted = 1'b0;
            end else if (instr_valid && instr_ready) begin
                if (exp_pc >= 32'h1000) begin
                    check_head("t6_fault", exp_pc, 32'h0, 1'b1);
                    model_halted = 1'b1;
                end else begin
                    check_head("t6_accept", exp_pc, exp_pc >> 2, 1'b0);
                    exp_pc = exp_pc + 32'd4;
                end
            end
            step();
        end
        redirect_valid = 1'b0;

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
